// File: rtl/board_sense_reader.sv
// Samples the scanner's column sense lines once per row dwell, debounces all 64 squares
// and queues one placed/lifted event per changed square for the game-logic controller.
`timescale 1ns/1ps
module board_sense_reader #(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned DEBOUNCE_SCANS = 2,
   parameter int unsigned FIFO_DEPTH     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  row_onehot,
   input  logic [7:0]  col_in,
   input  logic        ev_ready,
   input  logic        ovf_clr,
   output logic        ev_valid,
   output logic [6:0]  ev_data,
   output logic [63:0] board,
   output logic        overflow,
   output logic        frame_done
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [7:0] SettleMax = 8'(SETTLE_CYCLES);
   localparam logic [2:0] DebMax = 3'(DEBOUNCE_SCANS);
   localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

   typedef enum logic [1:0] {StWait, StSample, StWalk} state_t;

   // Input synchronizers
   logic [7:0] row_meta_q, row_sync_q;
   logic [7:0] col_meta_q, col_sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= '0;
         row_sync_q <= '0;
         col_meta_q <= '0;
         col_sync_q <= '0;
      end else begin
         row_meta_q <= row_onehot;
         row_sync_q <= row_meta_q;
         col_meta_q <= col_in;
         col_sync_q <= col_meta_q;
      end
   end

   // Row decode and dwell tracking
   logic       row_changed;
   logic       row_valid;
   logic [2:0] row_idx;
   logic [7:0] settle_q, settle_d;
   logic       sampled_q, sampled_d;
   logic       sample_go;

   state_t state_q, state_d;

   // A pending change sits in the meta stage; it lands in row_sync_q at the next edge.
   assign row_changed = (row_meta_q != row_sync_q);
   assign row_valid   = (row_sync_q != 8'd0) && ((row_sync_q & (row_sync_q - 8'd1)) == 8'd0);
   assign sample_go   = (settle_q == SettleMax) && !sampled_q;

   always_comb begin
      row_idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (row_sync_q[i]) begin
            row_idx = 3'(i);
         end
      end
   end

   always_comb begin
      settle_d = settle_q;
      if (row_changed || !row_valid) begin
         settle_d = 8'd0;
      end else if (settle_q != SettleMax) begin
         settle_d = settle_q + 8'd1;
      end
   end

   always_comb begin
      sampled_d = sampled_q;
      if (row_changed) begin
         sampled_d = 1'b0;
      end else if (state_q == StSample) begin
         sampled_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         settle_q  <= '0;
         sampled_q <= 1'b0;
      end else begin
         settle_q  <= settle_d;
         sampled_q <= sampled_d;
      end
   end

   // Debounce and board update
   logic [63:0] board_q, board_d;
   logic [1:0]  deb_q [64];
   logic [1:0]  deb_d [64];
   logic [7:0]  mask_q, mask_d;
   logic [2:0]  walk_row_q;
   logic [2:0]  walk_col_q;

   always_comb begin
      board_d = board_q;
      deb_d   = deb_q;
      mask_d  = 8'd0;
      if (state_q == StSample) begin
         for (int c = 0; c < 8; c++) begin
            if (col_sync_q[c] != board_q[{row_idx, 3'(c)}]) begin
               if (({1'b0, deb_q[{row_idx, 3'(c)}]} + 3'd1) >= DebMax) begin
                  board_d[{row_idx, 3'(c)}] = col_sync_q[c];
                  deb_d[{row_idx, 3'(c)}]   = 2'd0;
                  mask_d[c]                 = 1'b1;
               end else begin
                  deb_d[{row_idx, 3'(c)}] = deb_q[{row_idx, 3'(c)}] + 2'd1;
               end
            end else begin
               deb_d[{row_idx, 3'(c)}] = 2'd0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         board_q <= '0;
         for (int i = 0; i < 64; i++) begin
            deb_q[i] <= 2'd0;
         end
      end else begin
         board_q <= board_d;
         deb_q   <= deb_d;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StWait;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StWait: begin
            if (sample_go) begin
               state_d = StSample;
            end
         end
         StSample: begin
            state_d = (mask_d != 8'd0) ? StWalk : StWait;
         end
         StWalk: begin
            if (walk_col_q == 3'd7) begin
               state_d = StWait;
            end
         end
         default: state_d = StWait;
      endcase
   end

   // Walk context captured at sample time so a row change cannot disturb it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q     <= '0;
         walk_row_q <= '0;
         walk_col_q <= '0;
      end else if (state_q == StSample) begin
         mask_q     <= mask_d;
         walk_row_q <= row_idx;
         walk_col_q <= 3'd0;
      end else if (state_q == StWalk) begin
         walk_col_q <= walk_col_q + 3'd1;
      end
   end

   // FSM: outputs
   logic       push;
   logic [6:0] push_data;

   always_comb begin
      push       = 1'b0;
      push_data  = {board_q[{walk_row_q, walk_col_q}], walk_row_q, walk_col_q};
      frame_done = 1'b0;
      unique case (state_q)
         StSample: begin
            frame_done = (mask_d == 8'd0) && (row_idx == 3'd7);
         end
         StWalk: begin
            push       = mask_q[walk_col_q];
            frame_done = (walk_col_q == 3'd7) && (walk_row_q == 3'd7);
         end
         default: begin
         end
      endcase
   end

   // Event FIFO, show-ahead
   logic [6:0]      fifo_mem [FIFO_DEPTH];
   logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            full, pop, do_push, drop;
   logic            overflow_q, overflow_d;

   assign full     = (count_q == CntFull);
   assign ev_valid = (count_q != '0);
   assign pop      = ev_valid && ev_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push  = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign ev_data  = ev_valid ? fifo_mem[rd_ptr_q] : 7'd0;

   always_comb begin
      count_d = count_q;
      if (do_push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !do_push) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (ovf_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
         end
         if (do_push) begin
            wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
         end
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         fifo_mem[wr_ptr_q] <= push_data;
      end
   end

   assign board    = board_q;
   assign overflow = overflow_q;

endmodule

// File: doc/board_sense_reader.md
# board_sense_reader

Downstream consumer of the sensor row scanner. Follows the scanner's one-hot row select and samples the 8 column sense lines once per row dwell after a settle delay. Debounces each of the 64 squares into a stable occupancy map. Emits one placed/lifted event per changed square through a small FIFO with a valid/ready handshake for the game-logic controller.

## Interface
- SETTLE_CYCLES, 16: clk cycles between the synchronized row change and the column sample (range 1..255).
- DEBOUNCE_SCANS, 2: consecutive identical raw samples needed to flip a square (range 1..3).
- FIFO_DEPTH, 8: event FIFO entries (power of 2).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- row_onehot  in  8  row select from the scanner; bit r = row r driven.
- col_in  in  8  column sense lines, active-high = piece present on square (row, col).
- ev_ready  in  1  consumer accepts the event when ev_valid is high.
- ovf_clr  in  1  one-cycle pulse that clears overflow.
- ev_valid  out  1  FIFO head valid.
- ev_data  out  7  {placed, square[5:0]}; square = row*8 + col; placed=1 piece arrived, 0 piece lifted.
- board  out  64  debounced occupancy; bit square.
- overflow  out  1  sticky; event dropped on full FIFO.
- frame_done  out  1  one-cycle pulse after the row-7 sample has been fully processed.

## Operation
- row_onehot and col_in each pass through a 2-flop synchronizer; all logic below uses the synchronized values.
- Row is valid only when exactly one bit is set. A zero or multi-hot value clears the settle counter and blocks sampling.
- Settle counter: loads 0 on any change of the synchronized row value, then increments while the row is stable and valid, saturating at SETTLE_CYCLES.
- FSM states:
  - S_WAIT: go to S_SAMPLE when counter == SETTLE_CYCLES and the current dwell is not yet sampled.
  - S_SAMPLE (1 cycle): for row r, compare each col bit with board[r*8+c] and update that square's debounce counter. Bit differs: counter +1. Bit equal: counter cleared. A counter reaching DEBOUNCE_SCANS flips the board bit, clears the counter, and sets change-mask bit c. Marks the dwell as sampled. Goes to S_WALK if the mask is nonzero; otherwise to S_WAIT.
  - S_WALK: one column per cycle, col 0 to 7. For each set mask bit, push {board bit, r*8+c}. Return to S_WAIT after col 7. Always 8 cycles.
- A row change during S_WALK does not abort the walk. Its settle count runs in parallel, and its sample is deferred until S_WAIT.
- frame_done pulses the cycle the FSM leaves S_SAMPLE (empty mask) or S_WALK for row 7.
- FIFO: show-ahead; ev_data is the head entry whenever ev_valid is high. Pop when ev_valid && ev_ready.
  - Push when full (and no same-cycle pop): entry dropped, overflow set. board is still updated.
  - Push and pop in the same cycle when full: allowed, no drop.
- ovf_clr clears overflow. A drop in the same cycle wins, leaving overflow set.
- Board starts empty, so each occupied square yields a placed event once debounced after reset.

## Timing
- Reset values: board 0, all debounce counters 0, ev_valid 0, ev_data 0, overflow 0, frame_done 0, FIFO empty, FSM S_WAIT, settle counter 0, synchronizers 0.
- Latency, raw row_onehot edge to S_SAMPLE: 2 (sync) + SETTLE_CYCLES + 1 cycles.
- board updates at the end of the S_SAMPLE cycle.
- Event for column c is pushed on S_WALK cycle c (the first S_WALK cycle is c=0). ev_valid is high the following cycle when the FIFO was empty.
- Required row dwell is at least SETTLE_CYCLES + 12 clk cycles. Shorter dwells defer samples but never double-sample one dwell.
- rst mid-walk: the walk is abandoned, the FIFO is emptied, and pending events are lost.

## Test plan
- Reset: assert rst mid-S_WALK with 3 events queued -> all outputs at reset values; no events after release.
- Placement: DEBOUNCE_SCANS=2; hold col_in[5]=1 whenever row 3 is selected for 2 frames -> board[29] rises after second row-3 sample; single event ev_data=7'b1_011101; frame_done pulses every frame.
- Glitch rejection: col_in[2]=1 on row 0 for one frame only -> no event, board[2] stays 0; then lift a debounced piece at square 40 for 2 frames -> event {0,40}.
- Full row: row 6 goes 0x00 -> 0xFF, stable 2 frames -> 8 events, squares 48..55 in order, one per cycle with ev_ready=1.
- Overflow: ev_ready=0, FIFO_DEPTH=8, place 10 pieces -> 8 events retained, overflow=1; ovf_clr with ev_ready=1 -> overflow=0; 8 events drain in order.
- Invalid row: row_onehot=8'h00 then 8'h18 for 100 cycles -> no sample, no frame_done, board unchanged.
